dffrsnq_pipe: RTL and testbench



---
 rtl/dffrsnq_pipe.sv | 90 +++++++++
 tb/tb_dffrsnq_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dffrsnq_pipe.sv
// Stallable DEPTH-stage pipeline register built from async reset/set flops.
// Valid/ready flow control collapses bubbles, and all payload bits form one scan chain.
module dffrsnq_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             SETN,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic             D_RDY,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD,
  input  logic             Q_RDY,
  input  logic             SE,
  input  logic             SI,
  output logic             SO
);

  localparam int unsigned N = WIDTH * DEPTH;

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0]            adv;
  logic [N-1:0]                chain_q, chain_d;

  // Stage 0 occupies the low bits of the packed array, so the flat view is the scan order.
  assign chain_q = data_q;

  always_comb begin
    logic nxt;
    adv = '0;
    nxt = Q_RDY;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      nxt = !vld_q[DEPTH-1-j] | nxt;
      adv[DEPTH-1-j] = nxt;
    end
  end

  assign D_RDY = !SE && adv[0];

  always_comb begin
    chain_d    = '0;
    chain_d[0] = SI;
    for (int unsigned k = 1; k < N; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (SE) begin
      data_d = chain_d;
    end else begin
      if (adv[0]) begin
        data_d[0] = D;
        vld_d[0]  = D_VLD & D_RDY;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          data_d[i] = data_q[i-1];
          vld_d[i]  = vld_q[i-1];
        end
      end
    end
  end

  // Releasing RN while SETN is still low leaves RST_VAL until the next CLK edge applies SET_VAL.
  always_ff @(posedge CLK or negedge RN or negedge SETN) begin
    if (!RN) begin
      data_q <= {DEPTH{RST_VAL}};
      vld_q  <= '0;
    end else if (!SETN) begin
      data_q <= {DEPTH{SET_VAL}};
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign Q     = data_q[DEPTH-1];
  assign Q_VLD = vld_q[DEPTH-1];
  assign SO    = data_q[DEPTH-1][WIDTH-1];

endmodule

// File: tb/tb_dffrsnq_pipe.sv
// Bench for dffrsnq_pipe: directed scenarios plus a random stream, checked against
// a payload-position model of the pipe (items advance while there is room ahead).
module tb_dffrsnq_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned DP = 3;
  localparam int unsigned N  = W * DP;

  logic         CLK = 1'b0;
  logic         RN, SETN, D_VLD, Q_RDY, SE, SI;
  logic [W-1:0] D;
  logic         D_RDY, Q_VLD, SO;
  logic [W-1:0] Q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } item_t;

  item_t mq[$];
  bit    si_hist[$];

  dffrsnq_pipe #(.WIDTH(W), .DEPTH(DP), .RST_VAL(8'h00), .SET_VAL(8'hFF)) dut (
    .CLK(CLK), .RN(RN), .SETN(SETN), .D(D), .D_VLD(D_VLD), .D_RDY(D_RDY),
    .Q(Q), .Q_VLD(Q_VLD), .Q_RDY(Q_RDY), .SE(SE), .SI(SI), .SO(SO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input is accepted when, after every item moves as far as room allows, position 0 is free.
  function automatic bit model_rdy(input bit qr);
    int lim;
    lim = qr ? DP + 1 : DP;
    foreach (mq[k]) begin
      int np;
      np = mq[k].pos + 1;
      if (np > lim - 1) np = lim - 1;
      lim = np;
    end
    return lim >= 1;
  endfunction

  function automatic void model_clock(input bit qr, input bit dv, input logic [W-1:0] dd);
    bit rdy;
    int lim;
    rdy = model_rdy(qr);
    lim = qr ? DP + 1 : DP;
    foreach (mq[k]) begin
      int np;
      np = mq[k].pos + 1;
      if (np > lim - 1) np = lim - 1;
      mq[k].pos = np;
      lim = np;
    end
    while (mq.size() > 0 && mq[0].pos >= DP) void'(mq.pop_front());
    if (dv && rdy) mq.push_back('{d: dd, pos: 0});
  endfunction

  function automatic bit model_qvld();
    return mq.size() > 0 && mq[0].pos == DP - 1;
  endfunction

  // Called just after a falling edge: drive, check pre-edge state, clock, realign.
  task automatic cyc(input bit dv, input logic [W-1:0] dd, input bit qr);
    bit ev;
    D_VLD = dv; D = dd; Q_RDY = qr; SE = 1'b0;
    #1;
    ev = model_qvld();
    chk("d_rdy", {31'b0, D_RDY}, {31'b0, model_rdy(qr)});
    chk("q_vld", {31'b0, Q_VLD}, {31'b0, ev});
    if (ev) chk("q", {24'b0, Q}, {24'b0, mq[0].d});
    @(posedge CLK);
    model_clock(qr, dv, dd);
    @(negedge CLK);
  endtask

  initial begin
    int qv_cnt;
    int e;
    RN = 1'b0; SETN = 1'b0; SE = 1'b0; SI = 1'b0;
    D = '0; D_VLD = 1'b0; Q_RDY = 1'b0;

    // Reset dominates set
    #2;
    chk("rst_q",     {24'b0, Q},     32'h00);
    chk("rst_q_vld", {31'b0, Q_VLD}, 32'h0);
    chk("rst_so",    {31'b0, SO},    32'h0);
    #1 RN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("set_q",     {24'b0, Q},     32'hFF);
    chk("set_q_vld", {31'b0, Q_VLD}, 32'h0);
    chk("set_so",    {31'b0, SO},    32'h1);
    SETN = 1'b1;
    #1;
    chk("rel_d_rdy", {31'b0, D_RDY}, 32'h1);
    mq.delete();

    // Streaming at full rate: Q_VLD high for exactly three cycles
    qv_cnt = 0;
    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b1);
    cyc(1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (Q_VLD === 1'b1) qv_cnt++;
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("stream_vld_cycles", qv_cnt, 3);

    // Backpressure: fourth offer refused, then one-in-one-out
    cyc(1'b1, 8'hA1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0);
    cyc(1'b1, 8'hA4, 1'b0);
    cyc(1'b1, 8'hA4, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

    // Bubble collapse while stalled
    cyc(1'b1, 8'hB1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0);
    cyc(1'b1, 8'hB4, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

    // Async set with two payloads in flight
    cyc(1'b1, 8'hC1, 1'b1);
    cyc(1'b1, 8'hC2, 1'b1);
    D_VLD = 1'b0;
    #1 SETN = 1'b0;
    #1;
    chk("aset_q",     {24'b0, Q},     32'hFF);
    chk("aset_q_vld", {31'b0, Q_VLD}, 32'h0);
    #1 SETN = 1'b1;
    mq.delete();
    @(posedge CLK);
    model_clock(Q_RDY, 1'b0, 8'h00);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

    // Scan with a full pipe: valids hold, D_RDY low, SI reaches SO after N edges
    cyc(1'b1, 8'hD1, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0);
    cyc(1'b1, 8'hD3, 1'b0);
    e = 0;
    for (int k = 0; k < 2 * N; k++) begin
      bit b;
      b = (k < 4) ? ((4'b1101 >> k) & 1'b1) : 1'($urandom_range(0, 1));
      SE = 1'b1; SI = b;
      D_VLD = 1'($urandom_range(0, 1)); Q_RDY = 1'($urandom_range(0, 1)); D = 8'($urandom);
      #1;
      chk("scan_d_rdy", {31'b0, D_RDY}, 32'h0);
      chk("scan_q_vld", {31'b0, Q_VLD}, 32'h1);
      if (e >= N) chk("scan_so", {31'b0, SO}, {31'b0, si_hist[e-N]});
      @(posedge CLK);
      si_hist.push_back(b);
      e++;
      @(negedge CLK);
    end
    // Payloads now hold the bits that were shifted in; each flat position p carries edge e-1-p
    foreach (mq[k]) begin
      for (int b = 0; b < W; b++) mq[k].d[b] = si_hist[e - 1 - (mq[k].pos * W + b)];
    end
    SE = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
